// File: rtl/ralu_operand_fwd_if.sv
// ralu_operand_fwd_if
//  Bundles the S/E/M-side signals of the RALU operand-delivery unit.
//  master : the pipeline around the unit (drives S-stage requests, E-stage
//           producer info and the load bus; receives operands, stall, W state).
//  slave  : ralu_operand_fwd itself.
//
//  Handshake: ISSUE_S is the S-stage "valid", !STALL_S is the "ready". An
//  operand set transfers into OPND_E_R on a rising edge where
//  ISSUE_S & !STALL_S & !CLMI_RHOLD (and no reset). While STALL_S is high the
//  requester keeps ISSUE_S and its S-stage inputs stable.
//
//  Signals (direction seen from the slave):
//   in : CLMI_RHOLD, ISSUE_S, SRC_MODE_S, RF_RADDR_S, RF_RDATA_S, IMMED_S,
//        PCREL_S, ALURES_E, DEST_E, WEN_E, LOAD_E, RDBUSINM
//   out: OPND_E_R, Z_E, STALL_S, REGC_W_R, DEST_W_R, WEN_W_R
interface ralu_operand_fwd_if #(
  parameter int WIDTH  = 32,
  parameter int NPORTS = 3,
  parameter int AW     = 5
);
  logic                    CLMI_RHOLD;
  logic                    ISSUE_S;
  logic [NPORTS*2-1:0]     SRC_MODE_S;
  logic [NPORTS*AW-1:0]    RF_RADDR_S;
  logic [NPORTS*WIDTH-1:0] RF_RDATA_S;
  logic [WIDTH-1:0]        IMMED_S;
  logic [WIDTH-1:0]        PCREL_S;
  logic [WIDTH-1:0]        ALURES_E;
  logic [AW-1:0]           DEST_E;
  logic                    WEN_E;
  logic                    LOAD_E;
  logic [WIDTH-1:0]        RDBUSINM;
  logic [NPORTS*WIDTH-1:0] OPND_E_R;
  logic                    Z_E;
  logic                    STALL_S;
  logic [WIDTH-1:0]        REGC_W_R;
  logic [AW-1:0]           DEST_W_R;
  logic                    WEN_W_R;

  modport master (
    output CLMI_RHOLD, ISSUE_S, SRC_MODE_S, RF_RADDR_S, RF_RDATA_S, IMMED_S,
           PCREL_S, ALURES_E, DEST_E, WEN_E, LOAD_E, RDBUSINM,
    input  OPND_E_R, Z_E, STALL_S, REGC_W_R, DEST_W_R, WEN_W_R
  );

  modport slave (
    input  CLMI_RHOLD, ISSUE_S, SRC_MODE_S, RF_RADDR_S, RF_RDATA_S, IMMED_S,
           PCREL_S, ALURES_E, DEST_E, WEN_E, LOAD_E, RDBUSINM,
    output OPND_E_R, Z_E, STALL_S, REGC_W_R, DEST_W_R, WEN_W_R
  );
endinterface

// File: rtl/ralu_operand_fwd.sv
// ralu_operand_fwd
//  Operand delivery at the S->E boundary. Each port picks its source from its
//  mode (reg / immediate / pc-relative / zero). Register operands are bypassed
//  from the youngest E/M/W producer that matches; a match on a load still in E
//  is a load-use hazard. The block owns the M and W pipeline registers.
//
//  Ports:
//   SYSCLK      clock, rising edge
//   RESET_D1_R  synchronous reset, active high, overrides hold
//   bus         ralu_operand_fwd_if.slave (see the interface for signal list)
//
//  Parameters: WIDTH datapath, NPORTS operand ports (>= 2), AW address width,
//  FWD_EN 1 = bypass network, 0 = stall on any nonzero E/M/W address match.
module ralu_operand_fwd #(
  parameter int WIDTH  = 32,
  parameter int NPORTS = 3,
  parameter int AW     = 5,
  parameter bit FWD_EN = 1'b1
) (
  input logic               SYSCLK,
  input logic               RESET_D1_R,
  ralu_operand_fwd_if.slave bus
);

  localparam logic [1:0] MODE_REG   = 2'd0;
  localparam logic [1:0] MODE_IMMED = 2'd1;
  localparam logic [1:0] MODE_PCREL = 2'd2;
  localparam logic [1:0] MODE_ZERO  = 2'd3;

  // M stage state
  logic [WIDTH-1:0] alureg_m_q;
  logic [AW-1:0]    dest_m_q;
  logic             wen_m_q;
  logic             load_m_q;
  // W stage state
  logic [WIDTH-1:0] regc_w_q;
  logic [AW-1:0]    dest_w_q;
  logic             wen_w_q;
  // E operands
  logic [NPORTS*WIDTH-1:0] opnd_q;
  logic [NPORTS*WIDTH-1:0] opnd_d;

  logic [NPORTS*WIDTH-1:0] opnd_sel;
  logic [NPORTS-1:0]       port_haz;
  logic [WIDTH-1:0]        m_res;
  logic                    stall;

  // A load's data only exists on the bus during M, so the M result muxes it in.
  assign m_res = load_m_q ? bus.RDBUSINM : alureg_m_q;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [1:0]       mode;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rf;
    logic             hit_e;
    logic             hit_m;
    logic             hit_w;
    logic [WIDTH-1:0] sel;
    logic             haz;

    assign mode  = bus.SRC_MODE_S[p*2 +: 2];
    assign addr  = bus.RF_RADDR_S[p*AW +: AW];
    assign rf    = bus.RF_RDATA_S[p*WIDTH +: WIDTH];
    assign hit_e = bus.WEN_E && (bus.DEST_E == addr);
    assign hit_m = wen_m_q && (dest_m_q == addr);
    assign hit_w = wen_w_q && (dest_w_q == addr);

    always_comb begin
      sel = '0;
      haz = 1'b0;
      case (mode)
        MODE_REG: begin
          if (FWD_EN) begin
            // Youngest producer first; r0 never forwards and never stalls.
            if (addr == '0) begin
              sel = '0;
            end else if (hit_e) begin
              sel = bus.ALURES_E;
              haz = bus.LOAD_E;
            end else if (hit_m) begin
              sel = m_res;
            end else if (hit_w) begin
              sel = regc_w_q;
            end else begin
              sel = rf;
            end
          end else begin
            sel = rf;
            haz = (addr != '0) && (hit_e || hit_m || hit_w);
          end
        end
        MODE_IMMED: sel = bus.IMMED_S;
        MODE_PCREL: sel = bus.PCREL_S;
        MODE_ZERO:  sel = '0;
      endcase
    end

    assign opnd_sel[p*WIDTH +: WIDTH] = sel;
    assign port_haz[p]                = haz;
  end

  assign stall  = bus.ISSUE_S && (|port_haz);
  assign opnd_d = (bus.ISSUE_S && !stall) ? opnd_sel : opnd_q;

  always_ff @(posedge SYSCLK) begin
    if (RESET_D1_R) begin
      alureg_m_q <= '0;
      dest_m_q   <= '0;
      wen_m_q    <= 1'b0;
      load_m_q   <= 1'b0;
      regc_w_q   <= '0;
      dest_w_q   <= '0;
      wen_w_q    <= 1'b0;
      opnd_q     <= '0;
    end else if (!bus.CLMI_RHOLD) begin
      alureg_m_q <= bus.ALURES_E;
      dest_m_q   <= bus.DEST_E;
      wen_m_q    <= bus.WEN_E;
      load_m_q   <= bus.LOAD_E;
      regc_w_q   <= m_res;
      dest_w_q   <= dest_m_q;
      wen_w_q    <= wen_m_q;
      opnd_q     <= opnd_d;
    end
  end

  assign bus.OPND_E_R = opnd_q;
  assign bus.Z_E      = (opnd_q[0 +: WIDTH] == opnd_q[WIDTH +: WIDTH]);
  assign bus.STALL_S  = stall;
  assign bus.REGC_W_R = regc_w_q;
  assign bus.DEST_W_R = dest_w_q;
  assign bus.WEN_W_R  = wen_w_q;

endmodule

// File: tb/tb_ralu_operand_fwd.sv
module tb_ralu_operand_fwd;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ralu_operand_fwd_if #(.WIDTH(32), .NPORTS(3), .AW(5)) bus ();
  ralu_operand_fwd_if #(.WIDTH(32), .NPORTS(3), .AW(5)) bus2 ();

  ralu_operand_fwd #(.WIDTH(32), .NPORTS(3), .AW(5), .FWD_EN(1'b1)) u_dut (
    .SYSCLK     (clk),
    .RESET_D1_R (rst),
    .bus        (bus)
  );

  ralu_operand_fwd #(.WIDTH(32), .NPORTS(3), .AW(5), .FWD_EN(1'b0)) u_dut_nofwd (
    .SYSCLK     (clk),
    .RESET_D1_R (rst),
    .bus        (bus2)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input int p);
    logic [95:0] v;
    v = bus.OPND_E_R;
    return v[p*32 +: 32];
  endfunction

  function automatic logic [31:0] opnd2(input int p);
    logic [95:0] v;
    v = bus2.OPND_E_R;
    return v[p*32 +: 32];
  endfunction

  // drivers
  task automatic idle();
    bus.CLMI_RHOLD = 1'b0;
    bus.ISSUE_S    = 1'b0;
    bus.SRC_MODE_S = '0;
    bus.RF_RADDR_S = '0;
    bus.RF_RDATA_S = '0;
    bus.IMMED_S    = '0;
    bus.PCREL_S    = '0;
    bus.ALURES_E   = '0;
    bus.DEST_E     = '0;
    bus.WEN_E      = 1'b0;
    bus.LOAD_E     = 1'b0;
    bus.RDBUSINM   = '0;
  endtask

  task automatic idle2();
    bus2.CLMI_RHOLD = 1'b0;
    bus2.ISSUE_S    = 1'b0;
    bus2.SRC_MODE_S = '0;
    bus2.RF_RADDR_S = '0;
    bus2.RF_RDATA_S = '0;
    bus2.IMMED_S    = '0;
    bus2.PCREL_S    = '0;
    bus2.ALURES_E   = '0;
    bus2.DEST_E     = '0;
    bus2.WEN_E      = 1'b0;
    bus2.LOAD_E     = 1'b0;
    bus2.RDBUSINM   = '0;
  endtask

  task automatic set_e(input logic [31:0] val, input logic [4:0] dest,
                       input logic wen, input logic load);
    bus.ALURES_E = val;
    bus.DEST_E   = dest;
    bus.WEN_E    = wen;
    bus.LOAD_E   = load;
  endtask

  task automatic set_port(input int p, input logic [1:0] mode,
                          input logic [4:0] addr, input logic [31:0] rf);
    bus.SRC_MODE_S[p*2 +: 2]  = mode;
    bus.RF_RADDR_S[p*5 +: 5]  = addr;
    bus.RF_RDATA_S[p*32 +: 32] = rf;
  endtask

  task automatic randomize_inputs();
    bus.CLMI_RHOLD = 1'($urandom_range(0, 1));
    bus.ISSUE_S    = 1'($urandom_range(0, 1));
    bus.SRC_MODE_S = 6'($urandom_range(0, 63));
    bus.RF_RADDR_S = 15'($urandom);
    bus.RF_RDATA_S = {$urandom, $urandom, $urandom};
    bus.IMMED_S    = $urandom;
    bus.PCREL_S    = $urandom;
    bus.ALURES_E   = $urandom;
    bus.DEST_E     = 5'($urandom);
    bus.WEN_E      = 1'($urandom_range(0, 1));
    bus.LOAD_E     = 1'($urandom_range(0, 1));
    bus.RDBUSINM   = $urandom;
    bus2.ISSUE_S    = 1'($urandom_range(0, 1));
    bus2.CLMI_RHOLD = 1'($urandom_range(0, 1));
    bus2.ALURES_E   = $urandom;
    bus2.DEST_E     = 5'($urandom);
    bus2.WEN_E      = 1'($urandom_range(0, 1));
    bus2.RF_RADDR_S = 15'($urandom);
    bus2.RF_RDATA_S = {$urandom, $urandom, $urandom};
    bus2.SRC_MODE_S = 6'($urandom_range(0, 63));
    bus2.IMMED_S    = $urandom;
    bus2.PCREL_S    = $urandom;
    bus2.LOAD_E     = 1'($urandom_range(0, 1));
    bus2.RDBUSINM   = $urandom;
  endtask

  initial begin
    // ---- reset with random inputs ----
    rst = 1'b1;
    idle();
    idle2();
    randomize_inputs();
    tick();
    randomize_inputs();
    tick();
    idle();
    idle2();
    #1;
    chk("rst_opnd0", opnd(0), 32'h0);
    chk("rst_opnd1", opnd(1), 32'h0);
    chk("rst_opnd2", opnd(2), 32'h0);
    chk("rst_regc_w", bus.REGC_W_R, 32'h0);
    chk("rst_wen_w", 32'(bus.WEN_W_R), 32'h0);
    chk("rst_dest_w", 32'(bus.DEST_W_R), 32'h0);
    chk("rst_z_e", 32'(bus.Z_E), 32'h1);
    chk("rst_stall", 32'(bus.STALL_S), 32'h0);
    chk("rst_z_e_nofwd", 32'(bus2.Z_E), 32'h1);
    rst = 1'b0;
    tick();

    // ---- E bypass ----
    idle();
    set_e(32'h1234, 5'd5, 1'b1, 1'b0);
    set_port(0, 2'd0, 5'd5, 32'hDEAD);
    bus.ISSUE_S = 1'b1;
    #1;
    chk("ebyp_stall", 32'(bus.STALL_S), 32'h0);
    tick();
    chk("ebyp_opnd0", opnd(0), 32'h1234);
    chk("ebyp_opnd1", opnd(1), 32'h0);
    chk("ebyp_z_e", 32'(bus.Z_E), 32'h0);
    idle();
    tick();
    chk("alu_lat_regc_w", bus.REGC_W_R, 32'h1234);
    chk("alu_lat_dest_w", 32'(bus.DEST_W_R), 32'd5);
    chk("alu_lat_wen_w", 32'(bus.WEN_W_R), 32'h1);

    // ---- load-use ----
    idle();
    set_e(32'h1111, 5'd7, 1'b1, 1'b1);
    set_port(0, 2'd1, 5'd0, 32'h0);
    set_port(1, 2'd0, 5'd7, 32'hBEEF);
    bus.IMMED_S = 32'h55;
    bus.ISSUE_S = 1'b1;
    #1;
    chk("ldu_stall_on", 32'(bus.STALL_S), 32'h1);
    tick();
    chk("ldu_hold_opnd0", opnd(0), 32'h1234);
    chk("ldu_hold_opnd1", opnd(1), 32'h0);
    set_e(32'h0, 5'd0, 1'b0, 1'b0);
    bus.RDBUSINM = 32'hCAFE;
    #1;
    chk("ldu_stall_off", 32'(bus.STALL_S), 32'h0);
    tick();
    chk("ldu_opnd1", opnd(1), 32'hCAFE);
    chk("ldu_opnd0", opnd(0), 32'h55);
    chk("ldu_regc_w", bus.REGC_W_R, 32'hCAFE);
    chk("ldu_dest_w", 32'(bus.DEST_W_R), 32'd7);

    // ---- priority: E, M, W all on r3 ----
    idle();
    set_e(32'd3, 5'd3, 1'b1, 1'b0);
    tick();
    set_e(32'd2, 5'd3, 1'b1, 1'b0);
    tick();
    set_e(32'd1, 5'd3, 1'b1, 1'b0);
    set_port(0, 2'd0, 5'd3, 32'hAAAA);
    set_port(1, 2'd0, 5'd3, 32'hAAAA);
    set_port(2, 2'd0, 5'd3, 32'hAAAA);
    bus.ISSUE_S = 1'b1;
    #1;
    chk("prio_stall", 32'(bus.STALL_S), 32'h0);
    tick();
    chk("prio_e_opnd0", opnd(0), 32'd1);
    chk("prio_e_opnd1", opnd(1), 32'd1);
    chk("prio_e_opnd2", opnd(2), 32'd1);
    chk("prio_e_z_e", 32'(bus.Z_E), 32'h1);
    // M and W only
    idle();
    tick();
    set_e(32'd3, 5'd3, 1'b1, 1'b0);
    tick();
    set_e(32'd2, 5'd3, 1'b1, 1'b0);
    tick();
    idle();
    set_port(0, 2'd0, 5'd3, 32'hAAAA);
    set_port(2, 2'd0, 5'd3, 32'hAAAA);
    bus.ISSUE_S = 1'b1;
    tick();
    chk("prio_m_opnd0", opnd(0), 32'd2);
    chk("prio_m_opnd2", opnd(2), 32'd2);
    // W only
    idle();
    tick();
    set_e(32'd3, 5'd3, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    set_port(0, 2'd0, 5'd3, 32'hAAAA);
    bus.ISSUE_S = 1'b1;
    tick();
    chk("prio_w_opnd0", opnd(0), 32'd3);
    chk("prio_w_opnd1", opnd(1), 32'h0);
    // r0 with an E load targeting r0, plus pcrel and immediate modes
    idle();
    set_e(32'h77, 5'd0, 1'b1, 1'b1);
    set_port(0, 2'd0, 5'd0, 32'h99);
    set_port(1, 2'd2, 5'd0, 32'h0);
    set_port(2, 2'd1, 5'd0, 32'h0);
    bus.PCREL_S = 32'h12345678;
    bus.IMMED_S = 32'hABC;
    bus.ISSUE_S = 1'b1;
    #1;
    chk("r0_stall", 32'(bus.STALL_S), 32'h0);
    tick();
    chk("r0_opnd0", opnd(0), 32'h0);
    chk("pcrel_opnd1", opnd(1), 32'h12345678);
    chk("immed_opnd2", opnd(2), 32'hABC);

    // ---- hold for 3 cycles ----
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.CLMI_RHOLD = 1'b1;
      bus.ISSUE_S    = 1'b1;
      bus.SRC_MODE_S = 6'b01_01_01;
      bus.IMMED_S    = $urandom;
      set_e($urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b0);
      bus.RDBUSINM   = 32'hF00D;
      tick();
      chk("hold_opnd0", opnd(0), 32'h0);
      chk("hold_opnd1", opnd(1), 32'h12345678);
      chk("hold_opnd2", opnd(2), 32'hABC);
      chk("hold_wen_w", 32'(bus.WEN_W_R), 32'h0);
      chk("hold_regc_w", bus.REGC_W_R, 32'h0);
    end
    idle();
    set_e(32'h5A5A, 5'd9, 1'b1, 1'b0);
    bus.RDBUSINM = 32'hF00D;
    tick();
    chk("rel_regc_w", bus.REGC_W_R, 32'hF00D);
    chk("rel_wen_w", 32'(bus.WEN_W_R), 32'h1);
    chk("rel_dest_w", 32'(bus.DEST_W_R), 32'd0);
    idle();
    tick();
    chk("rel2_regc_w", bus.REGC_W_R, 32'h5A5A);
    chk("rel2_dest_w", 32'(bus.DEST_W_R), 32'd9);
    chk("rel2_opnd1", opnd(1), 32'h12345678);

    // ---- no-bypass instance: M/W matches stall until retired ----
    idle2();
    bus2.ALURES_E = 32'h44;
    bus2.DEST_E   = 5'd4;
    bus2.WEN_E    = 1'b1;
    tick();
    idle2();
    bus2.SRC_MODE_S[1:0] = 2'd0;
    bus2.RF_RADDR_S[4:0] = 5'd4;
    bus2.RF_RDATA_S[31:0] = 32'h4444;
    bus2.ISSUE_S = 1'b1;
    #1;
    chk("nofwd_stall_m", 32'(bus2.STALL_S), 32'h1);
    tick();
    chk("nofwd_stall_w", 32'(bus2.STALL_S), 32'h1);
    chk("nofwd_opnd0_held", opnd2(0), 32'h0);
    tick();
    chk("nofwd_stall_clear", 32'(bus2.STALL_S), 32'h0);
    chk("nofwd_opnd0_still", opnd2(0), 32'h0);
    tick();
    chk("nofwd_opnd0_rf", opnd2(0), 32'h4444);

    // ---- reset overrides hold, mid-stall ----
    idle();
    set_e(32'h1, 5'd8, 1'b1, 1'b1);
    set_port(0, 2'd0, 5'd8, 32'h0);
    bus.ISSUE_S    = 1'b1;
    bus.CLMI_RHOLD = 1'b1;
    #1;
    chk("rst2_stall_before", 32'(bus.STALL_S), 32'h1);
    rst = 1'b1;
    tick();
    chk("rst2_opnd1", opnd(1), 32'h0);
    chk("rst2_opnd2", opnd(2), 32'h0);
    chk("rst2_regc_w", bus.REGC_W_R, 32'h0);
    chk("rst2_wen_w", 32'(bus.WEN_W_R), 32'h0);
    chk("rst2_z_e", 32'(bus.Z_E), 32'h1);
    rst = 1'b0;
    idle();
    #1;
    chk("rst2_stall_after", 32'(bus.STALL_S), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
